// File: rtl/nor_input_debounce_if.sv
// rtl/nor_input_debounce_if.sv - raw inputs and conditioned outputs of the two-channel debouncer
// Ports (signals):
//   a_raw, b_raw       raw asynchronous levels into the conditioner
//   a, b               debounced levels, feed nor_gate.a / nor_gate.b
//   a_rise, a_fall     one-cycle pulses on accepted changes of a
//   b_rise, b_fall     one-cycle pulses on accepted changes of b
//   settled            both channels' synchronised levels match their outputs
// Modports: slave = debouncer side, master = driver/observer side.
interface nor_input_debounce_if;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic settled;

  modport slave (
    input  a_raw, b_raw,
    output a, b, a_rise, a_fall, b_rise, b_fall, settled
  );

  modport master (
    output a_raw, b_raw,
    input  a, b, a_rise, a_fall, b_rise, b_fall, settled
  );
endinterface

// File: rtl/nor_input_debounce.sv
// rtl/nor_input_debounce.sv - two-channel synchronise/debounce conditioner for nor_gate inputs
// Parameters:
//   STABLE_CYCLES  cycles a new synchronised level must persist before acceptance (2..2^CNT_W)
//   CNT_W          width of each per-channel stability counter
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   io             nor_input_debounce_if.slave: raw inputs, debounced levels, pulses, settled
module nor_input_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nor_input_debounce_if.slave    io
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_e;

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]            raw;
  logic [1:0]            s1_q, s1_d;
  logic [1:0]            s2_q, s2_d;
  logic [1:0]            out_q, out_d;
  logic [1:0]            rise_q, rise_d;
  logic [1:0]            fall_q, fall_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e                state_q [2];
  state_e                state_d [2];
  logic                  settled_q, settled_d;

  assign raw = {io.b_raw, io.a_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      out_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      cnt_q      <= '0;
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      settled_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      out_q      <= out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      settled_q  <= settled_d;
    end
  end

  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    settled_d = (s2_q == out_q);
    out_d     = out_q;
    rise_d    = '0;
    fall_d    = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          // First cycle of disagreement already counts as one.
          if (s2_q[i] != out_q[i]) begin
            state_d[i] = QUAL;
            cnt_d[i]   = CNT_ONE;
          end
        end
        QUAL: begin
          if (s2_q[i] == out_q[i]) begin
            // A single agreeing cycle discards all progress.
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            out_d[i]   = s2_q[i];
            rise_d[i]  = s2_q[i];
            fall_d[i]  = ~s2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign io.a       = out_q[0];
  assign io.b       = out_q[1];
  assign io.a_rise  = rise_q[0];
  assign io.a_fall  = fall_q[0];
  assign io.b_rise  = rise_q[1];
  assign io.b_fall  = fall_q[1];
  assign io.settled = settled_q;

endmodule

// File: tb/tb_nor_input_debounce.sv
// tb/tb_nor_input_debounce.sv - directed scoreboard bench for nor_input_debounce
module tb_nor_input_debounce;

  typedef struct {
    int code;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  ev_t  exp4 [$];
  ev_t  exp8 [$];

  nor_input_debounce_if if4 ();
  nor_input_debounce_if if8 ();

  nor_input_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if4)
  );

  nor_input_debounce #(.STABLE_CYCLES(8), .CNT_W(3)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if8)
  );

  logic nor_y;
  assign nor_y = ~(if4.a | if4.b);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input bit is8, input int code, input int at);
    ev_t ev;
    ev.code = code;
    ev.at   = at;
    if (is8) exp8.push_back(ev);
    else     exp4.push_back(ev);
  endtask

  // Pulse bits: 0 a_rise, 1 a_fall, 2 b_rise, 3 b_fall.
  task automatic mon_dut(input bit is8, input logic [3:0] p);
    ev_t ev;
    int  sz;
    chk(is8 ? "excl8" : "excl4", 32'((p[0] & p[1]) | (p[2] & p[3])), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (p[k]) begin
        sz = is8 ? exp8.size() : exp4.size();
        n_assert++;
        assert (sz > 0) else begin
          n_fail++;
          $error("FAIL unexpected_pulse: dut%0d code %0d at edge %0d, none expected", is8 ? 8 : 4, k, cyc);
        end
        if (sz > 0) begin
          ev = is8 ? exp8.pop_front() : exp4.pop_front();
          chk("pulse_code", 32'(k), 32'(ev.code));
          chk("pulse_edge", 32'(cyc), 32'(ev.at));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_dut(1'b0, {if4.b_fall, if4.b_rise, if4.a_fall, if4.a_rise});
    mon_dut(1'b1, {if8.b_fall, if8.b_rise, if8.a_fall, if8.a_rise});
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   k;
    logic ca, cb, na, nb;
    logic [1:0] pat [4];
    logic       exp_nor [4];
    pat     = '{2'b00, 2'b10, 2'b01, 2'b11};
    exp_nor = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Reset held with raw inputs high.
    if4.a_raw = 1'b1; if4.b_raw = 1'b1;
    if8.a_raw = 1'b0; if8.b_raw = 1'b0;
    wait_n(3);
    chk("rst_a", 32'(if4.a), 32'd0);
    chk("rst_b", 32'(if4.b), 32'd0);
    chk("rst_pulses", 32'({if4.a_rise, if4.a_fall, if4.b_rise, if4.b_fall}), 32'd0);
    chk("rst_settled", 32'(if4.settled), 32'd0);
    chk("rst_a8", 32'(if8.a), 32'd0);

    // Release: both channels accepted on edge 6 after release.
    k = cyc;
    rst_n = 1'b1;
    push(1'b0, 0, k + 6);
    push(1'b0, 2, k + 6);
    wait_n(5);
    chk("rel_a_early", 32'(if4.a), 32'd0);
    wait_n(1);
    chk("rel_a", 32'(if4.a), 32'd1);
    chk("rel_b", 32'(if4.b), 32'd1);
    wait_n(4);
    chk("rel_settled", 32'(if4.settled), 32'd1);
    chk("rel_settled8", 32'(if8.settled), 32'd1);

    // Simultaneous fall on both channels.
    k = cyc;
    if4.a_raw = 1'b0; if4.b_raw = 1'b0;
    push(1'b0, 1, k + 6);
    push(1'b0, 3, k + 6);
    wait_n(5);
    chk("sfall_a_early", 32'(if4.a), 32'd1);
    wait_n(1);
    chk("sfall_nor", 32'(nor_y), 32'd1);
    wait_n(4);
    chk("sfall_settled", 32'(if4.settled), 32'd1);

    // Clean rise on A: nor output goes 1 -> 0.
    k = cyc;
    if4.a_raw = 1'b1;
    push(1'b0, 0, k + 6);
    wait_n(5);
    chk("clean_nor_before", 32'(nor_y), 32'd1);
    wait_n(1);
    chk("clean_a", 32'(if4.a), 32'd1);
    chk("clean_nor_after", 32'(nor_y), 32'd0);
    wait_n(1);
    chk("clean_rise_gone", 32'(if4.a_rise), 32'd0);
    k = cyc;
    if4.a_raw = 1'b0;
    push(1'b0, 1, k + 6);
    wait_n(10);

    // Glitch: 3 cycles high is one short of acceptance.
    if4.a_raw = 1'b1;
    wait_n(3);
    if4.a_raw = 1'b0;
    wait_n(10);
    chk("glitch_a", 32'(if4.a), 32'd0);
    chk("glitch_settled", 32'(if4.settled), 32'd1);

    // High 3, low 1, high 4: one rise timed from the final rise, then a fall.
    if4.a_raw = 1'b1;
    wait_n(3);
    if4.a_raw = 1'b0;
    wait_n(1);
    k = cyc;
    if4.a_raw = 1'b1;
    push(1'b0, 0, k + 6);
    wait_n(4);
    if4.a_raw = 1'b0;
    push(1'b0, 1, k + 10);
    wait_n(12);
    chk("glitch2_a", 32'(if4.a), 32'd0);

    // Sweep 00, 10, 01, 11.
    ca = 1'b0; cb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      na = pat[i][1];
      nb = pat[i][0];
      k  = cyc;
      if (na != ca) push(1'b0, na ? 0 : 1, k + 6);
      if (nb != cb) push(1'b0, nb ? 2 : 3, k + 6);
      if4.a_raw = na;
      if4.b_raw = nb;
      wait_n(8);
      chk("sweep_nor", 32'(nor_y), 32'(exp_nor[i]));
      chk("sweep_settled", 32'(if4.settled), 32'd1);
      ca = na;
      cb = nb;
    end

    // Reset two cycles into qualification of an A fall.
    if4.a_raw = 1'b0;
    wait_n(4);
    chk("midq_cnt", 32'(u4.cnt_q[0]), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midq_a", 32'(if4.a), 32'd0);
    chk("midq_b", 32'(if4.b), 32'd0);
    chk("midq_settled", 32'(if4.settled), 32'd0);
    chk("midq_cnt_clr", 32'(u4.cnt_q[0]), 32'd0);
    wait_n(2);
    k = cyc;
    rst_n = 1'b1;
    push(1'b0, 2, k + 6);
    wait_n(5);
    chk("midq_b_early", 32'(if4.b), 32'd0);
    wait_n(1);
    chk("midq_b_req", 32'(if4.b), 32'd1);
    chk("midq_a_stays", 32'(if4.a), 32'd0);
    wait_n(4);

    // Max count: STABLE_CYCLES = 2^CNT_W = 8.
    k = cyc;
    if8.a_raw = 1'b1;
    push(1'b1, 0, k + 10);
    wait_n(2);
    for (int j = 1; j <= 7; j++) begin
      wait_n(1);
      chk("max_cnt", 32'(u8.cnt_q[0]), 32'(j));
    end
    chk("max_a_early", 32'(if8.a), 32'd0);
    wait_n(1);
    chk("max_a", 32'(if8.a), 32'd1);
    chk("max_cnt_clr", 32'(u8.cnt_q[0]), 32'd0);
    wait_n(3);

    chk("queue4_empty", 32'(exp4.size()), 32'd0);
    chk("queue8_empty", 32'(exp8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
